// File: rtl/load_stage.sv
// SHAKE input load stage: packs message words into a rate block,
// applies padding and hands blocks to the permutation stage.
module load_stage #(
  parameter int W             = 64,
  parameter int RATE_MAX      = 1344,
  parameter int RATE128_WORDS = 21,
  parameter int RATE256_WORDS = 17
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          operation_mode_in,
  input  logic [31:0]         input_size,
  input  logic [W-1:0]        data_in,
  input  logic                valid_in,
  output logic                ready_out,
  output logic [RATE_MAX-1:0] rate_input,
  output logic [1:0]          operation_mode,
  output logic                input_buffer_full,
  input  logic                input_buffer_ack,
  output logic                last_input_block,
  output logic                busy
);

  localparam int BPW = W / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PAD,
    S_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [31:0]         rem_q, rem_d;
  logic [4:0]          word_cnt_q, word_cnt_d;
  logic [7:0]          pos_q, pos_d;
  logic [RATE_MAX-1:0] buf_q, buf_d;
  logic                full_q, full_d;
  logic                last_q, last_d;

  logic [7:0]          rate_bytes;
  logic [31:0]         nbytes;
  logic [7:0]          pos_next;
  logic [W-1:0]        masked;
  logic                xfer;

  always_comb begin
    rate_bytes = (mode_q == 2'b00) ? 8'(RATE128_WORDS * BPW)
                                   : 8'(RATE256_WORDS * BPW);
    nbytes     = (rem_q < 32'(BPW)) ? rem_q : 32'(BPW);
    pos_next   = pos_q + nbytes[7:0];
    ready_out  = (state_q == S_LOAD) && (rem_q != 32'd0)
                 && (pos_q != rate_bytes);
    xfer       = ready_out && valid_in;
    masked     = '0;
    for (int k = 0; k < BPW; k++) begin
      if (32'(k) < rem_q) masked[8*k +: 8] = data_in[8*k +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    rem_d      = rem_q;
    word_cnt_d = word_cnt_q;
    pos_d      = pos_q;
    buf_d      = buf_q;
    full_d     = full_q;
    last_d     = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d     = operation_mode_in;
          rem_d      = input_size;
          word_cnt_d = '0;
          pos_d      = '0;
          buf_d      = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          buf_d[int'(word_cnt_q)*W +: W] = masked;
          word_cnt_d = word_cnt_q + 5'd1;
          pos_d      = pos_next;
          rem_d      = rem_q - nbytes;
          // A block counts as full only when every rate byte holds data
          if (pos_next == rate_bytes) begin
            full_d  = 1'b1;
            last_d  = 1'b0;
            state_d = S_WAIT;
          end
        end else if (rem_q == 32'd0) begin
          state_d = S_PAD;
        end
      end
      S_PAD: begin
        buf_d[int'(pos_q)*8 +: 8] = 8'h1F;
        buf_d[(int'(rate_bytes)-1)*8 +: 8] =
          buf_d[(int'(rate_bytes)-1)*8 +: 8] | 8'h80;
        full_d  = 1'b1;
        last_d  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (input_buffer_ack) begin
          buf_d      = '0;
          full_d     = 1'b0;
          word_cnt_d = '0;
          pos_d      = '0;
          if (last_q) begin
            last_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      rem_q      <= '0;
      word_cnt_q <= '0;
      pos_q      <= '0;
      buf_q      <= '0;
      full_q     <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      rem_q      <= rem_d;
      word_cnt_q <= word_cnt_d;
      pos_q      <= pos_d;
      buf_q      <= buf_d;
      full_q     <= full_d;
      last_q     <= last_d;
    end
  end

  assign rate_input        = buf_q;
  assign operation_mode    = mode_q;
  assign input_buffer_full = full_q;
  assign last_input_block  = last_q;
  assign busy              = (state_q != S_IDLE);

endmodule

// File: tb/tb_load_stage.sv
// Bench for load_stage: vector table driving a byte-level block model
// through a scoreboard, plus hand-written latency and reset sequences.
module tb_load_stage;
  localparam int W  = 64;
  localparam int RM = 1344;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1:0]    operation_mode_in;
  logic [31:0]   input_size;
  logic [W-1:0]  data_in;
  logic          valid_in;
  logic          ready_out;
  logic [RM-1:0] rate_input;
  logic [1:0]    operation_mode;
  logic          input_buffer_full;
  logic          input_buffer_ack;
  logic          last_input_block;
  logic          busy;

  load_stage dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .operation_mode_in (operation_mode_in),
    .input_size        (input_size),
    .data_in           (data_in),
    .valid_in          (valid_in),
    .ready_out         (ready_out),
    .rate_input        (rate_input),
    .operation_mode    (operation_mode),
    .input_buffer_full (input_buffer_full),
    .input_buffer_ack  (input_buffer_ack),
    .last_input_block  (last_input_block),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RM-1:0] data;
    logic          last;
  } blk_t;

  typedef struct {
    logic [1:0] mode;
    int         size;
    int         seed;
    bit         gaps;
    int         ack_dly;
    int         exp_blocks;
  } vec_t;

  blk_t sb[$];
  vec_t vecs[8];
  int   checks;
  int   errors;
  bit   ready_seen;

  always @(negedge clk) if (ready_out) ready_seen = 1'b1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_blk(input string name, input logic [RM-1:0] act,
                         input logic [RM-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int i = 0; i < RM/64; i++) begin
        if (act[i*64 +: 64] !== exp[i*64 +: 64]) begin
          $display("FAIL %s word %0d: got %h expected %h", name, i,
                   act[i*64 +: 64], exp[i*64 +: 64]);
          break;
        end
      end
    end
  endtask

  function automatic logic [63:0] msg_word(input int seed, input int j);
    return 64'hAABBCCDD00112233 ^ {32'(seed), 32'(j)};
  endfunction

  function automatic int rbytes(input logic [1:0] m);
    return (m == 2'b00) ? 168 : 136;
  endfunction

  task automatic push_model(input vec_t v);
    int rb;
    int nblk;
    int g;
    logic [63:0] mw;
    blk_t e;
    rb   = rbytes(v.mode);
    nblk = v.size / rb + 1;
    for (int b = 0; b < nblk; b++) begin
      e.data = '0;
      for (int i = 0; i < rb; i++) begin
        g = b * rb + i;
        if (g < v.size) begin
          mw = msg_word(v.seed, g / 8);
          e.data[i*8 +: 8] = mw[(g % 8)*8 +: 8];
        end
      end
      e.last = (b == nblk - 1);
      if (e.last) begin
        e.data[(v.size % rb)*8 +: 8] = e.data[(v.size % rb)*8 +: 8] | 8'h1F;
        e.data[(rb-1)*8 +: 8] = e.data[(rb-1)*8 +: 8] | 8'h80;
      end
      sb.push_back(e);
    end
  endtask

  task automatic do_start(input logic [1:0] m, input int sz);
    @(negedge clk);
    start = 1'b1;
    operation_mode_in = m;
    input_size = 32'(sz);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    int nw;
    int j;
    int budget;
    nw = (v.size + 7) / 8;
    j = 0;
    budget = 0;
    while (j < nw && budget < 2000) begin
      if (v.gaps && $urandom_range(0, 2) == 0) begin
        valid_in = 1'b0;
      end else begin
        valid_in = 1'b1;
        data_in  = msg_word(v.seed, j);
        if (ready_out) j++;
      end
      @(negedge clk);
      budget++;
    end
    valid_in = 1'b0;
    if (j < nw) begin
      checks++;
      errors++;
      $display("FAIL drive_timeout: sent %0d words, required %0d", j, nw);
    end
  endtask

  task automatic consume(input vec_t v);
    int got;
    int t;
    blk_t e;
    logic [RM-1:0] snap;
    got = 0;
    for (int b = 0; b < v.exp_blocks; b++) begin
      t = 0;
      while (!input_buffer_full && t < 500) begin
        @(negedge clk);
        t++;
      end
      if (!input_buffer_full) begin
        checks++;
        errors++;
        $display("FAIL full_timeout: block %0d never became full", b);
        break;
      end
      if (sb.size() > 0) e = sb.pop_front();
      else e = '{data: '0, last: 1'b0};
      chk_blk("block_data", rate_input, e.data);
      chk("block_last", 64'(last_input_block), 64'(e.last));
      chk("block_mode", 64'(operation_mode), 64'(v.mode));
      snap = rate_input;
      for (int d = 0; d < v.ack_dly; d++) begin
        @(negedge clk);
        chk("wait_ready", 64'(ready_out), 64'd0);
        chk_blk("wait_stable", rate_input, snap);
      end
      input_buffer_ack = 1'b1;
      @(negedge clk);
      input_buffer_ack = 1'b0;
      got++;
    end
    chk("block_count", 64'(got), 64'(v.exp_blocks));
    chk("idle_after", 64'({busy, input_buffer_full, last_input_block}),
        64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    sb.delete();
    ready_seen = 1'b0;
    push_model(v);
    do_start(v.mode, v.size);
    fork
      drive(v);
      consume(v);
    join
    if (v.size == 0) chk("size0_ready", 64'(ready_seen), 64'd0);
  endtask

  task automatic ack_pulse();
    input_buffer_ack = 1'b1;
    @(negedge clk);
    input_buffer_ack = 1'b0;
  endtask

  initial begin
    int n;
    int t;
    clk = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    operation_mode_in = 2'b00;
    input_size = '0;
    data_in = '0;
    valid_in = 1'b0;
    input_buffer_ack = 1'b0;
    checks = 0;
    errors = 0;

    //        mode   size seed gaps ackd blocks
    vecs[0] = '{2'b00,   0,  1, 1'b0,  0, 1};
    vecs[1] = '{2'b01,   3,  0, 1'b0,  0, 1};
    vecs[2] = '{2'b10, 135,  5, 1'b0,  1, 1};
    vecs[3] = '{2'b00, 168,  7, 1'b0,  0, 2};
    vecs[4] = '{2'b00, 400,  9, 1'b1, 10, 3};
    vecs[5] = '{2'b11, 272,  3, 1'b1,  2, 3};
    vecs[6] = '{2'b00, 167, 11, 1'b0,  0, 1};
    vecs[7] = '{2'b00,  20,  4, 1'b0,  0, 1};

    #12;
    chk("rst_ready", 64'(ready_out), 64'd0);
    chk("rst_full", 64'(input_buffer_full), 64'd0);
    chk("rst_last", 64'(last_input_block), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mode", 64'(operation_mode), 64'd0);
    chk_blk("rst_rate", rate_input, '0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // ack in IDLE must be ignored
    ack_pulse();
    chk("idle_ack_busy", 64'({busy, input_buffer_full}), 64'd0);

    // padded-block latency after the final word
    do_start(2'b01, 3);
    chk("lat_ready", 64'(ready_out), 64'd1);
    valid_in = 1'b1;
    data_in = 64'hAABBCCDD00112233;
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    chk("lat_pad_1", 64'(input_buffer_full), 64'd0);
    @(negedge clk);
    chk("lat_pad_2", 64'(input_buffer_full), 64'd1);
    chk("lat_pad_lo", rate_input[63:0], 64'h000000001F112233);
    chk("lat_pad_hi", rate_input[1343:1088] == '0 ? 64'd0 : 64'd1, 64'd0);
    ack_pulse();

    // size-0 latency after start
    do_start(2'b00, 0);
    chk("lat_z0", 64'(input_buffer_full), 64'd0);
    @(negedge clk);
    chk("lat_z1", 64'(input_buffer_full), 64'd0);
    @(negedge clk);
    chk("lat_z2", 64'(input_buffer_full), 64'd1);
    ack_pulse();

    // asynchronous reset in the middle of a load
    do_start(2'b11, 400);
    n = 0;
    t = 0;
    valid_in = 1'b1;
    while (n < 5 && t < 100) begin
      data_in = msg_word(2, n);
      if (ready_out) n++;
      @(negedge clk);
      t++;
    end
    valid_in = 1'b0;
    chk("pre_rst_busy", 64'({busy, operation_mode}), 64'b111);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(ready_out), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_mode", 64'(operation_mode), 64'd0);
    chk("mid_rst_flags", 64'({input_buffer_full, last_input_block}), 64'd0);
    chk_blk("mid_rst_rate", rate_input, '0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(vecs[7]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_stage.md
Name: load_stage

Overview:
- Input-side counterpart of the SHAKE output dump stage.
- Accepts the message as a stream of w-bit words (valid/ready), byte-masks the final partial word, and packs words into a rate-wide block buffer.
- Applies SHAKE padding and hands each completed block to the permutation stage through a full/ack handshake.
- Sits between the external input interface and the Keccak absorb/permutation stage.

Parameters:
- W, 64, input word width; equals w from keccak_pkg_mine.
- RATE_MAX, 1344, buffer width; equals RATE_SHAKE128.
- RATE128_WORDS, 21, words per SHAKE128 block (168 bytes).
- RATE256_WORDS, 17, words per SHAKE256 block (136 bytes).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin new message; sampled only in IDLE.
- operation_mode_in  in  2  00 = SHAKE128; any other value = SHAKE256; latched on start.
- input_size  in  32  message length in bytes; latched on start.
- data_in  in  W  message word; byte k of the word is bits 8k+7:8k (little-endian).
- valid_in  in  1  data_in valid.
- ready_out  out  1  stage accepts data_in this cycle.
- rate_input  out  RATE_MAX  block to absorb; word i is bits 64i+63:64i.
- operation_mode  out  2  latched mode, forwarded to the permutation stage.
- input_buffer_full  out  1  rate_input holds a complete block.
- input_buffer_ack  in  1  one-cycle pulse: permutation stage consumed the block.
- last_input_block  out  1  current block is the final, padded block.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset: all outputs 0, rate_input cleared, FSM to IDLE, counters cleared. Reset mid-message discards all state; start is accepted on the first cycle after rst deasserts.
- Handshake: a word transfers on a rising edge with valid_in && ready_out.
- ready_out = 1 only in LOAD while words_remaining > 0 and the block is not full. It does not depend on valid_in.
- Counters:
  - bytes_remaining (32b): loaded from input_size on start; decremented by min(8, bytes_remaining) per transfer.
  - word_cnt (5b): position within the current block; reset to 0 on each new block.
- Partial word masking: bytes at index >= bytes_remaining of the transferred word are written as 0x00.
- FSM transitions:
  - IDLE: on start, go to LOAD with an empty buffer.
  - LOAD, block full after a transfer: go to WAIT with last_input_block = 0. A block that ends exactly on the message boundary gets no padding; a pure padding block follows.
  - LOAD, bytes_remaining == 0 and block not full (includes size 0): go to PAD.
  - PAD (one cycle): write 0x1F at byte p = input_size mod rate_bytes of the current block, and OR 0x80 into byte rate_bytes-1. If p == rate_bytes-1 that byte is 0x9F. All bytes above p are zero. Set last_input_block = 1, go to WAIT.
  - WAIT: input_buffer_full = 1; rate_input, last_input_block and operation_mode are held stable.
  - WAIT with input_buffer_ack: clear the buffer and input_buffer_full. If last_input_block = 1, go to IDLE and clear last_input_block; otherwise go to LOAD.
- Data bits: for SHAKE256, bits 1343:1088 are always 0.
- Latency:
  - Full data block: input_buffer_full rises the cycle after the last word transfers.
  - Padded block: input_buffer_full rises two cycles after the last word (one PAD cycle), or two cycles after start for size 0.
- Ignored inputs:
  - input_buffer_ack outside WAIT.
  - start outside IDLE.
  - valid_in when ready_out = 0.
- The buffer is single; there is no overlap between loading and absorbing. ready_out = 0 in IDLE, PAD and WAIT.

Test Plan:
1. SHAKE128, size 0 -> ready_out never 1; single block with byte0 = 0x1F, byte167 = 0x80, all other bytes 0, last_input_block = 1; ack returns the stage to IDLE.
2. SHAKE256, size 3, word 0xAABBCCDD00112233 -> bytes 0..2 = 33 22 11, byte3 = 0x1F, bytes 4..134 = 0, byte135 = 0x80, bits 1343:1088 = 0.
3. SHAKE256, size 135, 17 words -> word 16 keeps 7 bytes with byte7 masked; byte135 = 0x9F; exactly one block, last = 1.
4. SHAKE128, size 168, 21 words -> block 1 is raw data with last = 0 and no padding; after ack, block 2 has byte0 = 0x1F, byte167 = 0x80, last = 1.
5. SHAKE128, size 400 with random valid_in gaps and ack held low for 10 cycles -> ready_out stays 0 and rate_input is stable while full. Three blocks total: two data blocks, then a third with bytes 0..63 data, byte64 = 0x1F, byte167 = 0x80.
6. rst asserted mid-LOAD after 5 words -> all outputs 0 immediately (async); a new start on the next cycle produces a correct block.
